fetch_stage: RTL

Instruction fetch stage of the cs3220 core. It owns the program counter, issues word reads to the synchronous-read instruction memory and presents each returned instruction with its PC on the `fetch_*` register set consumed by decode. It honours decode's stall/flush pair. A one-entry skid buffer preserves any in-flight read across a stall, so release never costs a bubble or a re-fetch.

---
 rtl/cs3220_pkg.sv | 20 ++
 rtl/fetch_skid.sv | 46 ++++
 rtl/fetch_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/cs3220_pkg.sv
// Shared types and constants for the cs3220 core front end.
package cs3220_pkg;

  // Instruction word presented to decode whenever no real instruction is available.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Sequential fetch advances the PC by one 32-bit word.
  localparam logic [31:0] PC_INCR = 32'd4;

  // Payload carried from fetch to decode.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_word_t;

  // Value of the fetch outputs while no instruction is present.
  localparam fetch_word_t FETCH_BUBBLE = '{valid: 1'b0, pc: 32'h0, inst: NOP_INST};

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register that parks an in-flight instruction memory read
// while decode is stalled, so it can be replayed on release without a re-fetch.
module fetch_skid
  import cs3220_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        clear,
  input  logic        load,
  input  logic        consume,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output fetch_word_t word
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  // Occupancy flag: clear (reset or flush) beats load, load beats consume.
  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  // Payload only changes on load; its contents are meaningless while empty.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q   <= 32'h0;
      inst_q <= NOP_INST;
    end else if (load) begin
      pc_q   <= load_pc;
      inst_q <= load_inst;
    end
  end

  assign valid = valid_q;
  assign word  = '{valid: valid_q, pc: pc_q, inst: inst_q};

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues reads to the synchronous-read
// instruction memory and registers {valid, pc, inst} for decode. A skid entry
// keeps the read that was in flight when a stall arrived, so release resumes
// the stream with neither a bubble nor a duplicate.
module fetch_stage
  import cs3220_pkg::*;
#(
  parameter int          IMEM_AW  = 12,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               decode_stall,
  input  logic               decode_flush,
  input  logic [31:0]        i_redirect_pc,
  output logic               fetch_valid,
  output logic [31:0]        fetch_pc,
  output logic [31:0]        fetch_inst
);

  logic [31:0] pc_q;
  logic        f1_valid;
  logic [31:0] f1_pc;
  fetch_word_t out_q;
  fetch_word_t out_next;

  logic        do_flush;
  logic        do_stall;
  logic        do_run;
  logic        sk_valid;
  fetch_word_t sk_word;

  // Priority is reset > flush > stall > run; exactly one mode is active when not in reset.
  assign do_flush = !i_reset && decode_flush;
  assign do_stall = !i_reset && !decode_flush && decode_stall;
  assign do_run   = !i_reset && !decode_flush && !decode_stall;

  // A new read is issued only in run cycles; high PC bits alias onto the memory.
  assign imem_en   = do_run;
  assign imem_addr = pc_q[IMEM_AW+1:2];

  fetch_skid u_skid (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .clear     (do_flush),
    .load      (do_stall && f1_valid && !sk_valid),
    .consume   (do_run && sk_valid),
    .load_pc   (f1_pc),
    .load_inst (imem_rdata),
    .valid     (sk_valid),
    .word      (sk_word)
  );

  // Output load source: skid first (it is older), then the read landing now, else a bubble.
  always_comb begin
    out_next = out_q;
    if (do_flush) begin
      out_next = FETCH_BUBBLE;
    end else if (do_run) begin
      if (sk_valid) begin
        out_next = '{valid: 1'b1, pc: sk_word.pc, inst: sk_word.inst};
      end else if (f1_valid) begin
        out_next = '{valid: 1'b1, pc: f1_pc, inst: imem_rdata};
      end else begin
        out_next = FETCH_BUBBLE;
      end
    end
  end

  // PC, in-flight request tracking and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q     <= RESET_PC;
      f1_valid <= 1'b0;
      f1_pc    <= 32'h0;
      out_q    <= FETCH_BUBBLE;
    end else begin
      out_q <= out_next;
      if (do_flush) begin
        // Word-align the redirect target; the read landing this cycle is dropped.
        pc_q     <= i_redirect_pc & ~32'h3;
        f1_valid <= 1'b0;
      end else if (do_stall) begin
        // Any in-flight read has just been parked in the skid, so nothing stays in flight.
        f1_valid <= 1'b0;
      end else begin
        f1_valid <= 1'b1;
        f1_pc    <= pc_q;
        pc_q     <= pc_q + PC_INCR;
      end
    end
  end

  assign fetch_valid = out_q.valid;
  assign fetch_pc    = out_q.pc;
  assign fetch_inst  = out_q.inst;

endmodule
